booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_pkg.sv | 45 ++++
 rtl/booth_control_unit.sv | 68 ++++++
 rtl/booth_multiplier.sv | 108 ++++++++++
 tb/tb_booth_multiplier.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier:
// FSM state encoding, iteration counts and Booth digit recoding helpers.
package booth_pkg;

    localparam int WIDTH       = 32;
    localparam int ITER_CNT_R2 = 32;
    localparam int ITER_CNT_R4 = 16;
    localparam int CNT_W       = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        OUT_HI,
        OUT_LO
    } state_e;

    // Bit 2 marks a negative digit, bits 1:0 give the magnitude (0, 1 or 2 times M).
    typedef enum logic [2:0] {
        BD_ZERO = 3'b000,
        BD_POS1 = 3'b001,
        BD_POS2 = 3'b010,
        BD_NEG1 = 3'b101,
        BD_NEG2 = 3'b110
    } booth_digit_e;

    function automatic booth_digit_e booth_r2_digit(input logic [1:0] bits);
        case (bits)
            2'b01:   return BD_POS1;
            2'b10:   return BD_NEG1;
            default: return BD_ZERO;
        endcase
    endfunction

    function automatic booth_digit_e booth_r4_digit(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return BD_POS1;
            3'b011:         return BD_POS2;
            3'b100:         return BD_NEG2;
            3'b101, 3'b110: return BD_NEG1;
            default:        return BD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_control_unit.sv
// Sequencing FSM and iteration counter for the Booth multiplier:
// IDLE -> LOAD -> ITER (ITER_CNT cycles) -> OUT_HI -> OUT_LO -> IDLE.
module booth_control_unit
    import booth_pkg::*;
#(
    parameter int ITER_CNT = ITER_CNT_R2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bgn_i,
    output logic load_o,
    output logic iter_o,
    output logic out_hi_o,
    output logic out_lo_o,
    output logic stop_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_o   = 1'b0;
        iter_o   = 1'b0;
        out_hi_o = 1'b0;
        out_lo_o = 1'b0;
        stop_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bgn_i) state_d = LOAD;
            end
            LOAD: begin
                load_o  = 1'b1;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                iter_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) state_d = OUT_HI;
            end
            OUT_HI: begin
                out_hi_o = 1'b1;
                state_d  = OUT_LO;
            end
            OUT_LO: begin
                out_lo_o = 1'b1;
                stop_o   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier: 64-bit product returned as high then low word.
// Define BOOTH_RADIX4_EN for radix-4 modified Booth (16 iterations); default is radix-2 (32).
module booth_multiplier #(
    parameter int WIDTH = booth_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             bgn,
    input  logic [WIDTH-1:0] ibusa,
    input  logic [WIDTH-1:0] ibusb,
    output logic [WIDTH-1:0] obus,
    output logic             stop
);
    import booth_pkg::*;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER_CNT = ITER_CNT_R4;
    localparam int AW       = WIDTH + 3;
`else
    localparam int ITER_CNT = ITER_CNT_R2;
    localparam int AW       = WIDTH + 2;
`endif

    logic                    load, iter, out_hi, out_lo, ctl_stop;
    logic signed [AW-1:0]    a_q, a_d, m_ext, addend, sum;
    logic signed [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic                    qm1_q, qm1_d;
    booth_digit_e            digit;

    booth_control_unit #(
        .ITER_CNT (ITER_CNT)
    ) u_ctl (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .bgn_i    (bgn),
        .load_o   (load),
        .iter_o   (iter),
        .out_hi_o (out_hi),
        .out_lo_o (out_lo),
        .stop_o   (ctl_stop)
    );

    // Accumulator carries extra sign bits so -M and -2M of the most negative M stay exact.
    always_comb begin
        m_ext = {{(AW-WIDTH){m_q[WIDTH-1]}}, m_q};
`ifdef BOOTH_RADIX4_EN
        digit = booth_r4_digit({q_q[1:0], qm1_q});
`else
        digit = booth_r2_digit({q_q[0], qm1_q});
`endif
        case (digit)
            BD_POS1: addend = m_ext;
            BD_POS2: addend = m_ext <<< 1;
            BD_NEG1: addend = -m_ext;
            BD_NEG2: addend = -(m_ext <<< 1);
            default: addend = '0;
        endcase
        sum = a_q + addend;
    end

    always_comb begin
        a_d   = a_q;
        m_d   = m_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        if (load) begin
            a_d   = '0;
            m_d   = ibusa;
            q_d   = ibusb;
            qm1_d = 1'b0;
        end else if (iter) begin
`ifdef BOOTH_RADIX4_EN
            a_d   = sum >>> 2;
            q_d   = {sum[1:0], q_q[WIDTH-1:2]};
            qm1_d = q_q[1];
`else
            a_d   = sum >>> 1;
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            a_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            m_q   <= m_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
        end
    end

    // Product sits in {A[WIDTH-1:0], Q}; outputs are forced low while reset is held.
    always_comb begin
        obus = '0;
        if (RESET && out_hi)      obus = a_q[WIDTH-1:0];
        else if (RESET && out_lo) obus = q_q;
    end

    assign stop = RESET & ctl_stop;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed table, random vs. arithmetic model,
// ignored-bgn, mid-operation reset and back-to-back sequences.
module tb_booth_multiplier;

`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 35;
`endif

    logic        CLK, RESET, bgn;
    logic [31:0] ibusa, ibusb, obus;
    logic        stop;

    int checks   = 0;
    int errors   = 0;
    int stop_cnt = 0;

    booth_multiplier #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bgn   (bgn),
        .ibusa (ibusa),
        .ibusb (ibusb),
        .obus  (obus),
        .stop  (stop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (stop === 1'b1) stop_cnt++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller has the clock just after an edge; the next rising edge is edge 0.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int glitch_k,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int st_edge, output logic [31:0] mid);
        logic [31:0] prev;
        ibusa = a; ibusb = b; bgn = 1'b1;
        st_edge = -1; hi = '0; lo = '0; prev = '0; mid = '1;
        @(posedge CLK); #1;
        bgn = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            bgn = (k == glitch_k);
            if (k == 2) begin
                ibusa = $urandom;
                ibusb = $urandom;
            end
            if (k == 10) mid = obus;
            if (stop === 1'b1) begin
                st_edge = k;
                hi = prev;
                lo = obus;
                break;
            end
            prev = obus;
        end
        bgn = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int glitch_k, input bit sync);
        logic [31:0] hi, lo, mid;
        int st, s0;
        if (sync) begin
            @(posedge CLK); #1;
        end
        s0 = stop_cnt;
        run_op(a, b, glitch_k, hi, lo, st, mid);
        #1;
        check($sformatf("%s hi", name), 64'(hi), 64'(exp[63:32]));
        check($sformatf("%s lo", name), 64'(lo), 64'(exp[31:0]));
        check($sformatf("%s stop_edge", name), 64'(st), 64'(LAT));
        check($sformatf("%s stop_count", name), 64'(stop_cnt - s0), 64'd1);
        check($sformatf("%s obus_iter", name), 64'(mid), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int s0;

        vecs[0] = '{32'd3,         32'd5,         64'h00000000_0000000F};
        vecs[1] = '{32'hFFFFFFF9,  32'd6,         64'hFFFFFFFF_FFFFFFD6};
        vecs[2] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
        vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001};
        vecs[4] = '{32'h00000000,  32'h80000000,  64'h00000000_00000000};
        vecs[5] = '{32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000};
        vecs[6] = '{32'h80000000,  32'h00000001,  64'hFFFFFFFF_80000000};
        vecs[7] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001};
        vecs[8] = '{32'hFFFFCFC7,  32'h00001A85,  64'hFFFFFFFF_FB012863};
        vecs[9] = '{32'h7FFFFFFF,  32'h80000000,  64'hC0000000_80000000};

        RESET = 1'b0; bgn = 1'b0; ibusa = '0; ibusb = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset obus", 64'(obus), 64'd0);
        check("reset stop", 64'(stop), 64'd0);
        RESET = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) ra = 32'h80000000;
            if (i % 7 == 2) rb = 32'hFFFFFFFF;
            do_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), 0, 1'b1);
        end

        // bgn pulsed during ITER cycle 10 must neither restart nor queue an operation.
        ra = 32'h12345678; rb = 32'hFEDCBA98;
        do_op("glitch", ra, rb, ref_mul(ra, rb), 12, 1'b1);
        s0 = stop_cnt;
        repeat (LAT + 8) @(posedge CLK);
        @(negedge CLK); #1;
        check("glitch no_restart", 64'(stop_cnt - s0), 64'd0);

        // Abort with reset during ITER cycle 20, restart on the first cycle after release.
        @(posedge CLK); #1;
        ibusa = 32'd1234567; ibusb = 32'hFFFFFFA7; bgn = 1'b1;
        @(posedge CLK); #1;
        bgn = 1'b0;
        repeat (21) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
            check("abort obus", 64'(obus), 64'd0);
            check("abort stop", 64'(stop), 64'd0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        do_op("after_reset", 32'd2, 32'd3, 64'd6, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
